// File: rtl/crc_pkg.sv
// Shared CRC-8 definitions for the serializer and the downstream checker:
// CRC register type, serializer state encoding and default polynomial/seed.
package crc_pkg;

    typedef logic [7:0] crc8_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        APPEND = 2'd2
    } ser_state_t;

    localparam crc8_t CRC8_POLY = 8'h07;
    localparam crc8_t CRC8_INIT = 8'h00;

endpackage

// File: rtl/crc8_step.sv
// Single-bit CRC-8 update (MSB-first, x^8 implicit). Purely combinational so
// the same block can sit in the serializer and in the downstream checker.
module crc8_step
    import crc_pkg::*;
(
    input  crc8_t crc_i,
    input  logic  bit_i,
    input  crc8_t poly_i,
    output crc8_t crc_o
);

    logic fb;

    // Feedback is the outgoing CRC MSB xor'd with the incoming data bit.
    always_comb begin
        fb    = crc_i[7] ^ bit_i;
        crc_o = {crc_i[6:0], 1'b0} ^ (fb ? poly_i : 8'h00);
    end

endmodule

// File: rtl/crc_serializer.sv
// Byte-to-bit serializer with running CRC-8 over the data stream.
// Build option: define CRC_SERIALIZER_APPEND_EN to append the CRC byte to each
// frame; without it the CRC is only reported on crc_out/crc_done.
//
// state  | meaning
// IDLE   | no frame in flight, ready for the first byte of a frame
// SHIFT  | presenting data bits; bit_valid=0 here means waiting for the next byte
// APPEND | presenting the 8 CRC bits (only with CRC_SERIALIZER_APPEND_EN)
module crc_serializer
    import crc_pkg::*;
#(
    parameter crc8_t POLY = CRC8_POLY,
    parameter crc8_t INIT = CRC8_INIT
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       bit_out,
    output logic       bit_valid,
    input  logic       out_ready,
    output logic       frame_sof,
    output logic       frame_eof,
    output crc8_t      crc_out,
    output logic       crc_done,
    output logic       busy
);

    ser_state_t state_q, state_d;
    logic [6:0] rest_q, rest_d;          // bits still to send after bit_out
    logic [2:0] bit_cnt_q, bit_cnt_d;
    crc8_t      crc_q, crc_d;
    crc8_t      crc_out_q, crc_out_d;
    crc8_t      crc_step;
    logic       last_q, last_d;
    logic       bit_out_q, bit_out_d;
    logic       bit_valid_q, bit_valid_d;
    logic       sof_q, sof_d;
    logic       eof_q, eof_d;
    logic       crc_done_q, crc_done_d;
    logic       busy_q;
    logic       accept;

    crc8_step u_step (
        .crc_i  (crc_q),
        .bit_i  (bit_out_q),
        .poly_i (POLY),
        .crc_o  (crc_step)
    );

    // Ready while idle, while starved between bytes, or when the 8th bit of a
    // non-last byte leaves this cycle; held low during reset.
    always_comb begin
        in_ready = reset_n &&
                   ((state_q == IDLE) ||
                    (state_q == SHIFT && !bit_valid_q) ||
                    (state_q == SHIFT && bit_cnt_q == 3'd7 && out_ready && !last_q));
        accept   = in_valid && in_ready;
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        rest_d      = rest_q;
        bit_cnt_d   = bit_cnt_q;
        crc_d       = crc_q;
        last_d      = last_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = bit_valid_q;
        sof_d       = sof_q;
        eof_d       = eof_q;
        crc_out_d   = crc_out_q;
        crc_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = SHIFT;
                    rest_d      = in_data[6:0];
                    bit_cnt_d   = 3'd0;
                    crc_d       = INIT;
                    last_d      = in_last;
                    bit_out_d   = in_data[7];
                    bit_valid_d = 1'b1;
                    sof_d       = 1'b1;
                    eof_d       = 1'b0;
                end
            end
            SHIFT: begin
                if (!bit_valid_q) begin
                    if (accept) begin
                        rest_d      = in_data[6:0];
                        bit_cnt_d   = 3'd0;
                        last_d      = in_last;
                        bit_out_d   = in_data[7];
                        bit_valid_d = 1'b1;
                    end
                end else if (out_ready) begin
                    crc_d = crc_step;
                    sof_d = 1'b0;
                    if (bit_cnt_q != 3'd7) begin
                        rest_d    = {rest_q[5:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        bit_out_d = rest_q[6];
`ifndef CRC_SERIALIZER_APPEND_EN
                        eof_d     = last_q && (bit_cnt_q == 3'd6);
`endif
                    end else if (last_q) begin
                        crc_out_d  = crc_step;
                        crc_done_d = 1'b1;
                        bit_cnt_d  = 3'd0;
                        eof_d      = 1'b0;
`ifdef CRC_SERIALIZER_APPEND_EN
                        state_d     = APPEND;
                        bit_out_d   = crc_step[7];
                        bit_valid_d = 1'b1;
`else
                        state_d     = IDLE;
                        bit_out_d   = 1'b0;
                        bit_valid_d = 1'b0;
`endif
                    end else if (accept) begin
                        rest_d    = in_data[6:0];
                        bit_cnt_d = 3'd0;
                        last_d    = in_last;
                        bit_out_d = in_data[7];
                    end else begin
                        bit_cnt_d   = 3'd0;
                        bit_out_d   = 1'b0;
                        bit_valid_d = 1'b0;
                    end
                end
            end
`ifdef CRC_SERIALIZER_APPEND_EN
            APPEND: begin
                if (out_ready) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d     = IDLE;
                        bit_cnt_d   = 3'd0;
                        bit_out_d   = 1'b0;
                        bit_valid_d = 1'b0;
                        eof_d       = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        bit_out_d = crc_out_q[3'd6 - bit_cnt_q];
                        eof_d     = (bit_cnt_q == 3'd6);
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; a reset drops any frame in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rest_q      <= '0;
            bit_cnt_q   <= '0;
            crc_q       <= '0;
            last_q      <= 1'b0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            crc_out_q   <= '0;
            crc_done_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rest_q      <= rest_d;
            bit_cnt_q   <= bit_cnt_d;
            crc_q       <= crc_d;
            last_q      <= last_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            crc_out_q   <= crc_out_d;
            crc_done_q  <= crc_done_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    // Output wiring.
    always_comb begin
        bit_out   = bit_out_q;
        bit_valid = bit_valid_q;
        frame_sof = sof_q;
        frame_eof = eof_q;
        crc_out   = crc_out_q;
        crc_done  = crc_done_q;
        busy      = busy_q;
    end

endmodule

// File: tb/tb_crc_serializer.sv
// Directed bench for crc_serializer: known CRC-8 vectors (poly 0x07, init 0x00),
// back-to-back and throttled streaming, and reset in the middle of a frame.
module tb_crc_serializer;
    import crc_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       bit_out;
    logic       bit_valid;
    logic       out_ready;
    logic       frame_sof;
    logic       frame_eof;
    crc8_t      crc_out;
    logic       crc_done;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] fb [0:15];

`ifdef CRC_SERIALIZER_APPEND_EN
    localparam int TAIL = 8;
`else
    localparam int TAIL = 0;
`endif

    crc_serializer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .out_ready (out_ready),
        .frame_sof (frame_sof),
        .frame_eof (frame_eof),
        .crc_out   (crc_out),
        .crc_done  (crc_done),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Streams fb[0..nb-1] as one frame and checks bits, markers, CRC and timing.
    // abort_at>0 asserts reset after that many consumed bits instead.
    task automatic run_frame(input string tag, input int nb, input logic [7:0] crc_exp,
                             input bit throttle, input int abort_at);
        int sent = 0, nbits = 0, ncyc = 0, post = 0;
        int first_vcyc = -1, first_bcyc = -1, acc_cyc = -1, eof_cyc = -1, eof_bits = -1;
        int sofs = 0, eofs = 0, dones = 0, done_bits = -1, holdbad = 0, sof_first = 0;
        int exp_bits;
        logic [127:0] got = '0, exp = '0;
        logic [7:0] done_crc = '0;
        logic [3:0] prev_vec = '0;
        bit seen_eof = 0, prev_ordy = 1'b1, prev_bv = 1'b0;
        for (int i = 0; i < nb; i++)
            for (int k = 7; k >= 0; k--) exp = {exp[126:0], fb[i][k]};
`ifdef CRC_SERIALIZER_APPEND_EN
        for (int k = 7; k >= 0; k--) exp = {exp[126:0], crc_exp[k]};
`endif
        exp_bits = nb * 8 + TAIL;
        while (ncyc < 3000) begin
            @(negedge clock);
            if (ncyc > 0 && !prev_ordy && prev_bv &&
                {bit_out, bit_valid, frame_sof, frame_eof} !== prev_vec) holdbad++;
            if (crc_done) begin dones++; done_crc = crc_out; done_bits = nbits; end
            if (seen_eof) begin
                post++;
                if (post == 3) break;
            end
            out_ready = throttle ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (sent < nb) begin
                in_valid = 1'b1; in_data = fb[sent]; in_last = (sent == nb - 1);
            end else begin
                in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
            end
            #1;
            if (bit_valid && first_vcyc < 0) first_vcyc = ncyc;
            if (bit_valid && out_ready) begin
                if (nbits == 0) begin first_bcyc = ncyc; sof_first = frame_sof; end
                if (frame_sof) sofs++;
                got = {got[126:0], bit_out};
                nbits++;
                if (frame_eof) begin eofs++; eof_bits = nbits; eof_cyc = ncyc; seen_eof = 1; end
            end
            if (in_valid && in_ready) begin
                if (sent == 0) acc_cyc = ncyc;
                sent++;
            end
            prev_ordy = out_ready;
            prev_bv   = bit_valid;
            prev_vec  = {bit_out, bit_valid, frame_sof, frame_eof};
            ncyc++;
            if (abort_at > 0 && nbits == abort_at) begin
                chk({tag, "_done_before_reset"}, dones, 0);
                #2 reset_n = 1'b0;
                in_valid = 1'b0;
                #1;
                chk({tag, "_outs_in_reset"},
                    {bit_out, bit_valid, frame_sof, frame_eof, crc_done, busy, in_ready}, 0);
                chk({tag, "_crc_out_in_reset"}, crc_out, 8'h00);
                repeat (3) @(negedge clock);
                chk({tag, "_no_done_in_reset"}, crc_done, 0);
                reset_n = 1'b1;
                #1;
                chk({tag, "_ready_after_reset"}, {in_ready, busy, bit_valid}, 3'b100);
                return;
            end
        end
        chk({tag, "_bits"}, got, exp);
        chk({tag, "_nbits"}, nbits, exp_bits);
        chk({tag, "_latency"}, first_vcyc, acc_cyc + 1);
        chk({tag, "_sof"}, {sof_first[0], sofs[7:0]}, {1'b1, 8'd1});
        chk({tag, "_eof"}, {eofs[7:0], eof_bits[7:0]}, {8'd1, exp_bits[7:0]});
        chk({tag, "_crc_done"}, {dones[7:0], done_crc}, {8'd1, crc_exp});
        chk({tag, "_done_at_bit"}, done_bits, nb * 8);
        chk({tag, "_crc_out_hold"}, crc_out, crc_exp);
        chk({tag, "_idle_after"}, {busy, bit_valid}, 2'b00);
        if (throttle) chk({tag, "_hold"}, holdbad, 0);
        else          chk({tag, "_no_gaps"}, eof_cyc - first_bcyc + 1, exp_bits);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset_outs", {bit_out, bit_valid, frame_sof, frame_eof, crc_done, busy, in_ready}, 0);
        chk("reset_crc_out", crc_out, 8'h00);
        reset_n = 1'b1;
        #1;
        chk("ready_after_reset", in_ready, 1);

        fb[0] = 8'h00;
        run_frame("zero_byte", 1, 8'h00, 0, 0);

        fb[0] = 8'h5D;
        run_frame("byte_5d", 1, 8'h94, 0, 0);

        for (int i = 0; i < 9; i++) fb[i] = 8'h31 + 8'(i);
        run_frame("seq_31_39", 9, 8'hF4, 0, 0);
        run_frame("seq_throttled", 9, 8'hF4, 1, 0);
        run_frame("seq_reset", 9, 8'hF4, 0, 20);

        fb[0] = 8'h5D;
        run_frame("post_reset_5d", 1, 8'h94, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
